bcd_step_counter: RTL

BCD_STEP_COUNTER -- requirements
Module: bcd_step_counter

---
 rtl/bcd_step_counter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/bcd_step_counter.sv
// ============================================================================
// Module      : bcd_step_counter
// Description : Two-button up/down counter over 0..3 for a 7-segment BCD
//               decoder. Each raw push button is synchronized (2 flops) and
//               debounced. A debounced rising edge on btn_inc or btn_dec
//               steps the count by +1 or -1, modulo 4. Simultaneous inc/dec
//               presses cancel each other.
//
// Parameters  : DEB_CYCLES     stable synchronized cycles needed before a
//                              button level is accepted (2..65535)
//               REPEAT_CYCLES  auto-repeat period in cycles (2..65535),
//                              only used when auto-repeat is built in
//
// Ports       : clk      in   1  single rising-edge clock
//               rst      in   1  asynchronous active-high reset
//               btn_inc  in   1  raw increment button, asynchronous
//               btn_dec  in   1  raw decrement button, asynchronous
//               out_bcd  out  4  registered {2'b00, count}
//               step     out  1  one-cycle pulse when out_bcd changes
//
// Macro       : BCD_STEP_AUTOREPEAT_EN
//               Defined   -> a single held button steps again every
//                            REPEAT_CYCLES cycles after the press step.
//               Undefined -> exactly one step per press, no repeat logic.
//
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_step_counter #(
  parameter int DEB_CYCLES    = 4,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [3:0] out_bcd,
  output logic       step
);

  // Counter width covers the full legal parameter range (up to 65535).
  localparam int                 C_CNT_W    = 16;
  localparam logic [C_CNT_W-1:0] C_DEB_LAST = C_CNT_W'(DEB_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  // Bit 0 is the increment button, bit 1 the decrement button.
  wire [1:0] w_raw;
  wire [1:0] w_press;
`ifdef BCD_STEP_AUTOREPEAT_EN
  wire [1:0] w_deb;
`endif

  assign w_raw = {btn_dec, btn_inc};

  // --------------------------------------------------------------------------
  // Per-button synchronizer, debouncer and rising-edge detector
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic               r_s1;
    logic               r_s2;
    logic               r_lvl;
    logic               r_lvl_prev;
    logic [C_CNT_W-1:0] r_deb_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s1       <= 1'b0;
        r_s2       <= 1'b0;
        r_lvl      <= 1'b0;
        r_lvl_prev <= 1'b0;
        r_deb_cnt  <= '0;
      end else begin
        r_s1       <= w_raw[gi];
        r_s2       <= r_s1;
        r_lvl_prev <= r_lvl;
        // The counter measures how long s2 has disagreed with the accepted
        // level; any agreement restarts the measurement.
        if (r_s2 == r_lvl) begin
          r_deb_cnt <= '0;
        end else if (r_deb_cnt == C_DEB_LAST) begin
          r_lvl     <= r_s2;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + C_CNT_ONE;
        end
      end
    end

    // Only a debounced rising edge is a press; releases never step.
    assign w_press[gi] = r_lvl & ~r_lvl_prev;
`ifdef BCD_STEP_AUTOREPEAT_EN
    assign w_deb[gi]   = r_lvl;
`endif
  end

  // --------------------------------------------------------------------------
  // Step requests (press events, plus auto-repeat when built in)
  // --------------------------------------------------------------------------
  logic w_inc_ev;
  logic w_dec_ev;

`ifdef BCD_STEP_AUTOREPEAT_EN
  localparam logic [C_CNT_W-1:0] C_REP_LAST = C_CNT_W'(REPEAT_CYCLES - 1);

  logic               r_rep_cnt_en_dummy_unused;
  logic [C_CNT_W-1:0] r_rep_cnt;
  logic               w_hold_one;
  logic               w_rep_fire;

  assign r_rep_cnt_en_dummy_unused = 1'b0;

  // Repeat timing runs only while exactly one button is held. The press
  // itself restarts the period so the first repeat lands REPEAT_CYCLES
  // after the press step.
  assign w_hold_one = w_deb[0] ^ w_deb[1];
  assign w_rep_fire = w_hold_one && !(|w_press) && (r_rep_cnt == C_REP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rep_cnt <= '0;
    end else if (!w_hold_one || (|w_press) || (r_rep_cnt == C_REP_LAST)) begin
      r_rep_cnt <= '0;
    end else begin
      r_rep_cnt <= r_rep_cnt + C_CNT_ONE;
    end
  end

  assign w_inc_ev = w_press[0] | (w_rep_fire & w_deb[0]);
  assign w_dec_ev = w_press[1] | (w_rep_fire & w_deb[1]);
`else
  assign w_inc_ev = w_press[0];
  assign w_dec_ev = w_press[1];
`endif

  // --------------------------------------------------------------------------
  // Count register and step pulse
  // --------------------------------------------------------------------------
  logic [1:0] r_count;
  logic       r_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 2'd0;
      r_step  <= 1'b0;
    end else begin
      r_step <= 1'b0;
      // Simultaneous inc and dec cancel; 2-bit arithmetic gives the mod-4 wrap.
      if (w_inc_ev ^ w_dec_ev) begin
        r_count <= w_inc_ev ? (r_count + 2'd1) : (r_count - 2'd1);
        r_step  <= 1'b1;
      end
    end
  end

  assign out_bcd = {2'b00, r_count};
  assign step    = r_step;

endmodule

`default_nettype wire
